// File: rtl/pico_fetch_seq_if.sv
// rtl/pico_fetch_seq_if.sv - ROM fetch and execute-stage hand-off bundle for pico_fetch_seq
interface pico_fetch_seq_if;
    logic        rom_en;
    logic [11:0] rom_add;
    logic [17:0] inst;
    logic [17:0] exec_inst;
    logic        exec_valid;

    // Sequencer side: drives the ROM request and the execute stage.
    modport master (
        output rom_en,
        output rom_add,
        output exec_inst,
        output exec_valid,
        input  inst
    );

    // ROM / execute side.
    modport slave (
        input  rom_en,
        input  rom_add,
        input  exec_inst,
        input  exec_valid,
        output inst
    );
endinterface

// File: rtl/pico_fetch_seq.sv
// rtl/pico_fetch_seq.sv - PicoBlaze-style two-state instruction fetch sequencer with call stack
module pico_fetch_seq #(
    parameter int          STACK_DEPTH  = 30,
    parameter logic [11:0] INT_VECTOR   = 12'h3FF,
    parameter logic [11:0] RESET_VECTOR = 12'h000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_zero_flag,
    input  logic             i_carry_flag,
    input  logic             i_irq,
    output logic             o_irq_ack,
    output logic             o_stack_overflow,
    output logic             o_stack_underflow,
    pico_fetch_seq_if.master bus
);
    localparam int             SPW     = $clog2(STACK_DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    localparam logic [0:0] S_ISSUE   = 1'b0;
    localparam logic [0:0] S_CAPTURE = 1'b1;

    logic [0:0]     r_state;
    logic [11:0]    r_pc;
    logic [SPW-1:0] r_sp;
    logic           r_ie;
    logic [17:0]    r_exec_inst;
    logic           r_exec_valid;
    logic           r_irq_ack;
    logic           r_overflow;
    logic           r_underflow;
    logic [11:0]    r_stack [STACK_DEPTH];

    logic [5:0]     w_op;
    logic [11:0]    w_target;
    logic [11:0]    w_pc_inc;
    logic           w_issue;
    logic           w_capture;
    logic           w_irq_take;
    logic           w_cond;
    logic           w_is_jump;
    logic           w_is_call;
    logic           w_is_ret;
    logic           w_is_reti;
    logic           w_is_ie;
    logic           w_take_branch;
    logic           w_push;
    logic           w_pop;
    logic [11:0]    w_push_data;
    logic           w_sp_full;
    logic           w_sp_empty;
    logic [SPW-1:0] w_top_idx;

    assign w_op        = bus.inst[17:12];
    assign w_target    = bus.inst[11:0];
    assign w_pc_inc    = r_pc + 12'd1;
    assign w_issue     = (r_state == S_ISSUE);
    assign w_capture   = (r_state == S_CAPTURE);
    assign w_irq_take  = w_issue & i_run & i_irq & r_ie;
    assign w_sp_full   = (r_sp == SP_FULL);
    assign w_sp_empty  = (r_sp == '0);
    assign w_top_idx   = r_sp - 1'b1;

    // The ROM is synchronous: the request goes out combinationally in ISSUE so the word is back in CAPTURE.
    assign bus.rom_en     = ~i_reset & w_issue & i_run & ~(i_irq & r_ie);
    assign bus.rom_add    = r_pc;
    assign bus.exec_inst  = r_exec_inst;
    assign bus.exec_valid = r_exec_valid;
    assign o_irq_ack         = r_irq_ack;
    assign o_stack_overflow  = r_overflow;
    assign o_stack_underflow = r_underflow;

    // Decode flow-control opcodes; ops 3x carry the condition in op[3:2] and the kind in op[1:0].
    always_comb begin
        w_cond    = 1'b0;
        w_is_jump = 1'b0;
        w_is_call = 1'b0;
        w_is_ret  = 1'b0;
        w_is_reti = 1'b0;
        w_is_ie   = 1'b0;
        if (w_op[5:4] == 2'b11) begin
            case (w_op[3:2])
                2'b00:   w_cond = i_zero_flag;
                2'b01:   w_cond = ~i_zero_flag;
                2'b10:   w_cond = i_carry_flag;
                default: w_cond = ~i_carry_flag;
            endcase
            case (w_op[1:0])
                2'b10:   w_is_jump = 1'b1;
                2'b00:   w_is_call = 1'b1;
                2'b01:   w_is_ret  = 1'b1;
                default: ;
            endcase
        end else begin
            w_cond = 1'b1;
            case (w_op)
                6'h22:   w_is_jump = 1'b1;
                6'h20:   w_is_call = 1'b1;
                6'h25:   w_is_ret  = 1'b1;
                6'h29:   w_is_reti = 1'b1;
                6'h28:   w_is_ie   = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_take_branch = w_capture & (w_is_jump | w_is_call) & w_cond;
    assign w_pop         = w_capture & ((w_is_ret & w_cond) | w_is_reti);
    assign w_push        = w_irq_take | (w_capture & w_is_call & w_cond);
    assign w_push_data   = w_irq_take ? r_pc : w_pc_inc;

    // Return-address storage; a push onto a full stack is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push && !w_sp_full) begin
            r_stack[r_sp] <= w_push_data;
        end
    end

    // Sequencer state, PC, stack pointer, interrupt enable and strobes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_ISSUE;
            r_pc         <= RESET_VECTOR;
            r_sp         <= '0;
            r_ie         <= 1'b0;
            r_exec_inst  <= 18'd0;
            r_exec_valid <= 1'b0;
            r_irq_ack    <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_exec_valid <= 1'b0;
            r_irq_ack    <= 1'b0;

            if (w_push) begin
                if (w_sp_full) r_overflow <= 1'b1;
                else           r_sp       <= r_sp + 1'b1;
            end else if (w_pop) begin
                if (w_sp_empty) r_underflow <= 1'b1;
                else            r_sp        <= w_top_idx;
            end

            if (w_issue) begin
                if (w_irq_take) begin
                    r_pc      <= INT_VECTOR;
                    r_ie      <= 1'b0;
                    r_irq_ack <= 1'b1;
                end else if (i_run) begin
                    r_state <= S_CAPTURE;
                end
            end else begin
                r_exec_inst  <= bus.inst;
                r_exec_valid <= 1'b1;
                r_state      <= S_ISSUE;
                if (w_take_branch) begin
                    r_pc <= w_target;
                end else if (w_pop) begin
                    r_pc <= w_sp_empty ? RESET_VECTOR : r_stack[w_top_idx];
                end else begin
                    r_pc <= w_pc_inc;
                end
                if (w_is_ie || w_is_reti) begin
                    r_ie <= bus.inst[0];
                end
            end
        end
    end
endmodule

// File: tb/tb_pico_fetch_seq.sv
// tb/tb_pico_fetch_seq.sv - directed self-checking bench for pico_fetch_seq
module tb_pico_fetch_seq;
    logic clk;
    logic reset;
    logic run;
    logic zero_flag;
    logic carry_flag;
    logic irq;
    logic irq_ack;
    logic stack_overflow;
    logic stack_underflow;

    int total;
    int bad;

    logic [17:0] rom [4096];

    pico_fetch_seq_if bus ();

    pico_fetch_seq dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_run             (run),
        .i_zero_flag       (zero_flag),
        .i_carry_flag      (carry_flag),
        .i_irq             (irq),
        .o_irq_ack         (irq_ack),
        .o_stack_overflow  (stack_overflow),
        .o_stack_underflow (stack_underflow),
        .bus               (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: word appears the cycle after rom_en.
    always @(posedge clk) begin
        if (bus.rom_en) bus.inst <= rom[bus.rom_add];
    end

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 18'h0;
    endtask

    // Leaves the bench at a falling edge with reset released and run low.
    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        irq = 1'b0;
        zero_flag = 1'b0;
        carry_flag = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Finds the next ISSUE cycle that requests the ROM; returns its address and the idle cycles before it.
    task automatic next_fetch(input bit skip, output logic [11:0] a, output int cyc);
        bit found;
        found = 1'b0;
        a = 12'hxxx;
        cyc = -1;
        if (skip) @(negedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            if (bus.rom_en === 1'b1) begin
                a = bus.rom_add;
                cyc = i;
                found = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL fetch_timeout got=no_fetch want=fetch_within_20");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b1;
        irq = 1'b0;
        zero_flag = 1'b0;
        carry_flag = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.rom_en !== 1'b0) begin bad++; $display("FAIL reset_rom_en got=%b want=0", bus.rom_en); end
        total++; if (bus.rom_add !== 12'h000) begin bad++; $display("FAIL reset_rom_add got=%h want=000", bus.rom_add); end
        total++; if (bus.exec_valid !== 1'b0) begin bad++; $display("FAIL reset_exec_valid got=%b want=0", bus.exec_valid); end
        total++; if (bus.exec_inst !== 18'h0) begin bad++; $display("FAIL reset_exec_inst got=%h want=00000", bus.exec_inst); end
        total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL reset_irq_ack got=%b want=0", irq_ack); end
        total++; if ({stack_overflow, stack_underflow} !== 2'b00) begin bad++; $display("FAIL reset_err_flags got=%b want=00", {stack_overflow, stack_underflow}); end
    endtask

    task automatic test_sequential();
        logic [11:0] a;
        int c;
        clear_rom();
        rom[12'h000] = 18'h01005;
        rom[12'h001] = 18'h01107;
        do_reset();
        run = 1'b1;
        next_fetch(1'b0, a, c);
        total++; if (a !== 12'h000) begin bad++; $display("FAIL seq_first_add got=%h want=000", a); end
        total++; if (bus.exec_valid !== 1'b0) begin bad++; $display("FAIL seq_no_early_valid got=%b want=0", bus.exec_valid); end
        @(negedge clk); #1;
        total++; if (bus.exec_valid !== 1'b0) begin bad++; $display("FAIL seq_capture_valid got=%b want=0", bus.exec_valid); end
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h001) begin bad++; $display("FAIL seq_second_add got=%h want=001", a); end
        total++; if (c !== 0) begin bad++; $display("FAIL seq_period got=%0d want=0", c); end
        total++; if ({bus.exec_valid, bus.exec_inst} !== {1'b1, 18'h01005}) begin bad++; $display("FAIL seq_exec0 got=%b/%h want=1/01005", bus.exec_valid, bus.exec_inst); end
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h002) begin bad++; $display("FAIL seq_third_add got=%h want=002", a); end
        total++; if ({bus.exec_valid, bus.exec_inst} !== {1'b1, 18'h01107}) begin bad++; $display("FAIL seq_exec1 got=%b/%h want=1/01107", bus.exec_valid, bus.exec_inst); end
    endtask

    task automatic test_flow();
        logic [11:0] a;
        int c;
        clear_rom();
        rom[12'h000] = 18'h22010;
        rom[12'h010] = 18'h20100;
        rom[12'h100] = 18'h25000;
        do_reset();
        run = 1'b1;
        next_fetch(1'b0, a, c);
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h010) begin bad++; $display("FAIL flow_jump got=%h want=010", a); end
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h100) begin bad++; $display("FAIL flow_call got=%h want=100", a); end
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h011) begin bad++; $display("FAIL flow_return got=%h want=011", a); end
    endtask

    task automatic test_conditional();
        logic [11:0] a;
        int c;
        clear_rom();
        rom[12'h000] = 18'h32020;
        rom[12'h001] = 18'h32020;
        rom[12'h020] = 18'h3C030;
        rom[12'h030] = 18'h25000;
        do_reset();
        run = 1'b1;
        next_fetch(1'b0, a, c);
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h001) begin bad++; $display("FAIL cond_jz_not_taken got=%h want=001", a); end
        zero_flag = 1'b1;
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h020) begin bad++; $display("FAIL cond_jz_taken got=%h want=020", a); end
        carry_flag = 1'b0;
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h030) begin bad++; $display("FAIL cond_callnc_taken got=%h want=030", a); end
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h021) begin bad++; $display("FAIL cond_callnc_pushed got=%h want=021", a); end
    endtask

    task automatic test_interrupt();
        logic [11:0] a;
        int c;
        clear_rom();
        rom[12'h000] = 18'h28001;
        rom[12'h3FF] = 18'h29001;
        do_reset();
        run = 1'b1;
        next_fetch(1'b0, a, c);
        next_fetch(1'b1, a, c);
        @(negedge clk);
        irq = 1'b1;
        @(negedge clk); #1;
        total++; if ({bus.rom_en, irq_ack} !== 2'b00) begin bad++; $display("FAIL irq_accept_cycle got=%b want=00", {bus.rom_en, irq_ack}); end
        @(negedge clk); #1;
        total++; if ({irq_ack, bus.rom_en, bus.rom_add} !== {1'b1, 1'b1, 12'h3FF}) begin bad++; $display("FAIL irq_vector got=%b/%b/%h want=1/1/3ff", irq_ack, bus.rom_en, bus.rom_add); end
        @(negedge clk);
        irq = 1'b0;
        #1;
        total++; if (irq_ack !== 1'b0) begin bad++; $display("FAIL irq_ack_single got=%b want=0", irq_ack); end
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h002) begin bad++; $display("FAIL irq_resume got=%h want=002", a); end
        @(negedge clk);
        irq = 1'b1;
        @(negedge clk); #1;
        total++; if (bus.rom_en !== 1'b0) begin bad++; $display("FAIL irq_reenabled got=%b want=0", bus.rom_en); end
        @(negedge clk); #1;
        total++; if ({irq_ack, bus.rom_add} !== {1'b1, 12'h3FF}) begin bad++; $display("FAIL irq_second got=%b/%h want=1/3ff", irq_ack, bus.rom_add); end
        irq = 1'b0;
    endtask

    task automatic test_stack_limits();
        logic [11:0] a;
        int c;
        clear_rom();
        for (int k = 0; k <= 30; k++) rom[k] = {6'h20, 12'(k + 1)};
        rom[31] = 18'h25000;
        do_reset();
        run = 1'b1;
        next_fetch(1'b0, a, c);
        for (int k = 1; k <= 31; k++) begin
            next_fetch(1'b1, a, c);
            total++; if (a !== 12'(k)) begin bad++; $display("FAIL stack_nest_%0d got=%h want=%h", k, a, 12'(k)); end
            if (k == 30) begin
                total++; if (stack_overflow !== 1'b0) begin bad++; $display("FAIL stack_no_ovf_30 got=%b want=0", stack_overflow); end
            end
        end
        total++; if (stack_overflow !== 1'b1) begin bad++; $display("FAIL stack_ovf_31 got=%b want=1", stack_overflow); end
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h01E) begin bad++; $display("FAIL stack_top_intact got=%h want=01e", a); end
        total++; if (stack_overflow !== 1'b1) begin bad++; $display("FAIL stack_ovf_sticky got=%b want=1", stack_overflow); end

        clear_rom();
        rom[12'h000] = 18'h25000;
        do_reset();
        run = 1'b1;
        next_fetch(1'b0, a, c);
        total++; if (stack_underflow !== 1'b0) begin bad++; $display("FAIL stack_no_unf got=%b want=0", stack_underflow); end
        next_fetch(1'b1, a, c);
        total++; if ({stack_underflow, a} !== {1'b1, 12'h000}) begin bad++; $display("FAIL stack_unf got=%b/%h want=1/000", stack_underflow, a); end
    endtask

    task automatic test_wrap_halt();
        logic [11:0] a;
        int c;
        clear_rom();
        rom[12'h000] = 18'h22FFF;
        rom[12'hFFF] = 18'h0A5A5;
        do_reset();
        run = 1'b1;
        next_fetch(1'b0, a, c);
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'hFFF) begin bad++; $display("FAIL wrap_reach_fff got=%h want=fff", a); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        total++; if ({bus.exec_valid, bus.rom_en} !== 2'b00) begin bad++; $display("FAIL reset_in_capture got=%b want=00", {bus.exec_valid, bus.rom_en}); end
        reset = 1'b0;
        next_fetch(1'b0, a, c);
        total++; if ({a, c} !== {12'h000, 32'sd0}) begin bad++; $display("FAIL reset_refetch got=%h/%0d want=000/0", a, c); end
        next_fetch(1'b1, a, c);
        next_fetch(1'b1, a, c);
        total++; if (a !== 12'h000) begin bad++; $display("FAIL wrap_fff_to_000 got=%h want=000", a); end
        total++; if (bus.exec_inst !== 18'h0A5A5) begin bad++; $display("FAIL wrap_exec_inst got=%h want=0a5a5", bus.exec_inst); end
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if ({bus.rom_en, bus.rom_add} !== {1'b0, 12'h000}) begin bad++; $display("FAIL halt_%0d got=%b/%h want=0/000", i, bus.rom_en, bus.rom_add); end
        end
        run = 1'b1;
        next_fetch(1'b0, a, c);
        total++; if (a !== 12'h000) begin bad++; $display("FAIL halt_resume got=%h want=000", a); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        run = 1'b0;
        zero_flag = 1'b0;
        carry_flag = 1'b0;
        irq = 1'b0;
        clear_rom();
        test_reset();
        test_sequential();
        test_flow();
        test_conditional();
        test_interrupt();
        test_stack_limits();
        test_wrap_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
